seq_mul: RTL and testbench

Parametrised sequential shift-and-add multiplier: the multi-cycle, width-generic successor to the team's 4-bit combinational array multiplier. It trades area for latency (one partial product per clock), supports unsigned and two's-complement operands selected per operation, and moves data through valid/ready handshakes on both sides. It sits as a shared arithmetic unit between a command source and a result consumer in the datapath.

---
 rtl/seq_mul.sv | 131 +++++++++++++
 tb/tb_seq_mul.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mul.sv
`default_nettype none
// ============================================================================
//  Module   : seq_mul
//  Purpose  : Width-generic sequential shift-and-add multiplier. It computes
//             one partial product per clock and supports unsigned or
//             two's-complement operands, selected per operation. Operands
//             and results move through valid/ready handshakes.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   1        rising-edge clock
//    rst_n       in   1        asynchronous active-low reset
//    in_valid    in   1        a, b and signed_mode are valid
//    in_ready    out  1        operation can be accepted (IDLE only)
//    a           in   WIDTH    multiplicand
//    b           in   WIDTH    multiplier
//    signed_mode in   1        1 = two's-complement operands, 0 = unsigned
//    out_valid   out  1        p holds a completed product (DONE only)
//    out_ready   in   1        consumer accepts p
//    p           out  2*WIDTH  product; keeps its last value after handshake
//    busy        out  1        operation in flight (CALC or DONE)
// ============================================================================
module seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int                 CNT_W    = $clog2(WIDTH + 1);
  localparam int                 ACC_W    = 2 * WIDTH + 1;
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]   ONE_C    = CNT_W'(1);
  localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_P    = (2 * WIDTH)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic               neg_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] p_q;

  logic [WIDTH-1:0]   a_mag_d;
  logic [WIDTH-1:0]   b_mag_d;
  logic [WIDTH:0]     sum_d;
  logic [ACC_W-1:0]   acc_d;
  logic [2*WIDTH-1:0] prod_d;
  logic [2*WIDTH-1:0] p_d;

  always_comb begin
    // Magnitudes of signed operands; the most negative value maps to
    // 2^(WIDTH-1), which is still representable as an unsigned WIDTH-bit word.
    a_mag_d = (signed_mode && a[WIDTH-1]) ? (~a + ONE_W) : a;
    b_mag_d = (signed_mode && b[WIDTH-1]) ? (~b + ONE_W) : b;

    // One shift-and-add step: conditionally add the multiplicand into the
    // upper half (carry lands in the extra top bit), then shift right.
    sum_d  = acc_q[ACC_W-1:WIDTH] + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH + 1){1'b0}});
    acc_d  = {sum_d, acc_q[WIDTH-1:0]} >> 1;
    prod_d = acc_d[2*WIDTH-1:0];
    p_d    = neg_q ? (~prod_d + ONE_P) : prod_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mcand_q  <= a_mag_d;
            mplier_q <= b_mag_d;
            neg_q    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= CALC;
          end
        end
        CALC: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + ONE_C;
          // The last step's result goes straight into p, so the product is
          // visible in the same edge that enters DONE.
          if (cnt_q == LAST_CNT) begin
            p_q     <= p_d;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC) || (state_q == DONE);
  assign p         = p_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_mul.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_mul
//  Purpose  : Self-checking bench for seq_mul at WIDTH = 4, 8 and 16. Each
//             instance has its own driver and a cycle-level behavioural model
//             (plain multiplication plus acceptance-to-valid timing) that is
//             compared against the outputs on every falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_mul;

  localparam int N_RAND = 1500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit done_flag [3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int W = (gi == 0) ? 4 : ((gi == 1) ? 8 : 16);

    logic           rst_n       = 1'b0;
    logic           in_valid    = 1'b0;
    logic           in_ready;
    logic [W-1:0]   a           = '0;
    logic [W-1:0]   b           = '0;
    logic           signed_mode = 1'b0;
    logic           out_valid;
    logic           out_ready   = 1'b0;
    logic [2*W-1:0] p;
    logic           busy;

    seq_mul #(.WIDTH(W)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .signed_mode (signed_mode),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .p           (p),
      .busy        (busy)
    );

    // Reference product from plain integer arithmetic.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic s);
      longint lx, ly, pr;
      lx = s ? longint'($signed(x)) : longint'(x);
      ly = s ? longint'($signed(y)) : longint'(y);
      pr = lx * ly;
      return pr[2*W-1:0];
    endfunction

    // Sum of shifted partial products, as the old combinational array did.
    function automatic logic [2*W-1:0] arr_mul(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [2*W-1:0] acc;
      acc = '0;
      for (int i = 0; i < W; i++)
        if (y[i]) acc = acc + ({{W{1'b0}}, x} << i);
      return acc;
    endfunction

    function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
        0:       return '0;
        1:       return '1;
        2:       return {1'b1, {(W-1){1'b0}}};
        3:       return {1'b0, {(W-1){1'b1}}};
        default: return W'($urandom);
      endcase
    endfunction

    // Behavioural model: m_left counts edges until the product appears.
    int             m_left = -1;
    bit             m_ov   = 1'b0;
    logic [2*W-1:0] m_p    = '0;
    logic [2*W-1:0] m_pend = '0;

    always @(negedge clk) begin
      if (!rst_n) begin
        m_left = -1;
        m_ov   = 1'b0;
        m_p    = '0;
      end
      chk($sformatf("w%0d model p", W), p, m_p);
      chk($sformatf("w%0d model out_valid", W), out_valid, m_ov);
      chk($sformatf("w%0d model busy", W), busy, (m_left > 0) || m_ov);
      chk($sformatf("w%0d model in_ready", W), in_ready, !((m_left > 0) || m_ov));
      if (rst_n) begin
        if (m_ov) begin
          if (out_ready) m_ov = 1'b0;
        end else if (m_left > 0) begin
          m_left--;
          if (m_left == 0) begin
            m_ov   = 1'b1;
            m_p    = m_pend;
            m_left = -1;
          end
        end else if (in_valid) begin
          m_pend = ref_mul(a, b, signed_mode);
          m_left = W;
        end
      end
    end

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                          input int stall, output logic [2*W-1:0] res, output int lat);
      int guard;
      guard = 0;
      while (!in_ready && guard < 64) begin
        @(posedge clk); #1;
        guard++;
      end
      chk($sformatf("w%0d in_ready before issue", W), in_ready, 1'b1);
      a = x; b = y; signed_mode = s; in_valid = 1'b1; out_ready = 1'($urandom);
      @(posedge clk); #1;
      lat = 0;
      // Scramble inputs while computing; they must not influence the result.
      while (!out_valid && lat < 4 * W) begin
        in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom);
        signed_mode = 1'($urandom); out_ready = 1'($urandom);
        @(posedge clk); #1;
        lat++;
      end
      out_ready = 1'b0;
      res = p;
      for (int i = 0; i < stall; i++) begin
        in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom);
        @(posedge clk); #1;
        chk($sformatf("w%0d stall out_valid", W), out_valid, 1'b1);
        chk($sformatf("w%0d stall in_ready", W), in_ready, 1'b0);
        chk($sformatf("w%0d stall p", W), p, ref_mul(x, y, s));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk($sformatf("w%0d post-handshake in_ready", W), in_ready, 1'b1);
      chk($sformatf("w%0d post-handshake out_valid", W), out_valid, 1'b0);
    endtask

    task automatic directed();
      logic [2*W-1:0] r;
      int             l;
      run_op(W'(13), W'(11), 1'b0, 0, r, l);
      chk("u 13*11 p", r, 64'd143);
      chk("u 13*11 latency", l, 64'd8);
      run_op(W'(8'hFF), W'(8'hFF), 1'b0, 0, r, l);
      chk("u FF*FF p", r, 64'hFE01);
      run_op(W'(0), W'(8'hFF), 1'b0, 0, r, l);
      chk("u 0*FF p", r, 64'd0);
      chk("u 0*FF latency", l, 64'd8);
      run_op(W'(8'hFD), W'(8'd7), 1'b1, 0, r, l);
      chk("s -3*7 p", r, 64'hFFEB);
      run_op(W'(8'h80), W'(8'h80), 1'b1, 0, r, l);
      chk("s 80*80 p", r, 64'h4000);
      run_op(W'(8'h80), W'(8'h7F), 1'b1, 0, r, l);
      chk("s 80*7F p", r, 64'hC080);
      run_op(W'(200), W'(3), 1'b0, 5, r, l);
      chk("backpressure p", r, 64'd600);

      // Reset in the 4th CALC cycle (between E3 and E4).
      a = W'(100); b = W'(7); signed_mode = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("busy before reset", busy, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid reset in_ready", in_ready, 1'b1);
      chk("mid reset out_valid", out_valid, 1'b0);
      chk("mid reset busy", busy, 1'b0);
      chk("mid reset p", p, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_op(W'(2), W'(3), 1'b0, 0, r, l);
      chk("after reset 2*3 p", r, 64'd6);
      chk("after reset latency", l, 64'd8);
    endtask

    initial begin
      logic [2*W-1:0] r;
      int             l;
      logic [W-1:0]   x, y;
      logic           s;
      int             stall;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("w%0d reset in_ready", W), in_ready, 1'b1);
      chk($sformatf("w%0d reset out_valid", W), out_valid, 1'b0);
      chk($sformatf("w%0d reset busy", W), busy, 1'b0);
      chk($sformatf("w%0d reset p", W), p, 64'd0);
      rst_n = 1'b1;

      if (W == 8) directed();

      if (W == 4) begin
        for (int i = 0; i < 16; i++) begin
          for (int j = 0; j < 16; j++) begin
            x = W'(i); y = W'(j);
            run_op(x, y, 1'b0, int'($urandom_range(0, 1)), r, l);
            chk("w4 array match", r, arr_mul(x, y));
          end
        end
      end

      for (int n = 0; n < N_RAND; n++) begin
        s = 1'($urandom);
        x = pick();
        y = pick();
        stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
        run_op(x, y, s, stall, r, l);
        chk($sformatf("w%0d rand p", W), r, ref_mul(x, y, s));
        chk($sformatf("w%0d rand latency", W), l, W);
      end
      done_flag[gi] = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(done_flag[0] && done_flag[1] && done_flag[2]) && t < 90000) begin
      @(posedge clk);
      t++;
    end
    chk("all instances finished", {done_flag[0], done_flag[1], done_flag[2]}, 64'd7);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
